id_ex_skid_reg: RTL and testbench

- ID/EX pipeline register directly upstream of the ALU. It captures the decoded operands, the ALU operation and the writeback tag, and presents them to the ALU and the EX stage.
- Valid/ready handshake on both sides with a 2-entry skid buffer. This gives full throughput with registered back-pressure.
- Synchronous flush for branch and jump squash.
- Saturating counter of downstream stall cycles for performance debug.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/ex_payload_reg.sv | 27 ++
 rtl/id_ex_skid_reg.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_skid_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU / execute-stage definitions.
//
// Contents:
//   DATA_W, REG_IDX_W, ALU_OP_W  - datapath, register-index and opcode widths
//   ALU_ADD .. ALU_SLL           - ALU operation codes (6 and 7 are unused and
//                                  produce 0 in the ALU)
//   ex_payload_t                 - instruction payload carried into EX, reused
//                                  by the ALU and the EX/MEM register
//   skid_state_e                 - occupancy of a 2-entry skid register,
//                                  encoded as {main_valid, skid_valid}
//   wb_enable()                  - writeback enable with the x0 rule applied
package alu_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned ALU_OP_W  = 3;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'd5;

  typedef struct packed {
    logic [DATA_W-1:0]    a;
    logic [DATA_W-1:0]    b;
    logic [ALU_OP_W-1:0]  alu_op;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
  } ex_payload_t;

  // Bit 1 is main_valid, bit 0 is skid_valid; 2'b01 is never reached.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull  = 2'b10,
    StSkid  = 2'b11
  } skid_state_e;

  // Writes to x0 are architecturally discarded, so drop the enable at capture.
  function automatic logic wb_enable(input logic [REG_IDX_W-1:0] rd,
                                     input logic                 reg_write);
    return reg_write && (rd != '0);
  endfunction

endpackage

// File: rtl/ex_payload_reg.sv
// Payload register with load enable and asynchronous active-high reset.
//
// Ports:
//   clk    - clock, captures on rising edge
//   reset  - asynchronous active-high reset, clears q to 0
//   load   - capture d on the next rising edge
//   d      - next payload value
//   q      - held payload
module ex_payload_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register feeding the ALU, with a 2-entry skid buffer.
//
// The upstream ready is derived from registered occupancy and flush only, so
// back-pressure from EX never forms a combinational path back into decode,
// while the second (skid) entry still allows one instruction per cycle.
//
// Ports:
//   clk, reset            - clock; asynchronous active-high reset
//   flush                 - synchronous squash of all held entries
//   in_valid / in_ready   - decode-side handshake
//   in_a, in_b            - ALU operands
//   in_alu_op             - ALU operation code (passed through unmodified)
//   in_rd, in_reg_write   - writeback tag; enable forced to 0 for x0
//   out_valid / out_ready - EX-side handshake
//   out_a .. out_reg_write- held instruction toward ALU/EX
//   stall_cycles          - saturating count of downstream stall cycles
module id_ex_skid_reg
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,

  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_a,
  input  logic [DATA_W-1:0]    in_b,
  input  logic [OP_W-1:0]      in_alu_op,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic                 in_reg_write,

  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_a,
  output logic [DATA_W-1:0]    out_b,
  output logic [OP_W-1:0]      out_alu_op,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic                 out_reg_write,

  output logic [CNT_W-1:0]     stall_cycles
);

  // Flattened payload: {a, b, alu_op, rd, reg_write}, same order as ex_payload_t.
  localparam int unsigned PW = 2 * DATA_W + OP_W + REG_IDX_W + 1;

  skid_state_e state_q;

  logic          main_valid;
  logic          skid_valid;
  logic          accept;
  logic          fire;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_d;
  logic [PW-1:0] main_q;
  logic [PW-1:0] skid_q;
  logic          load_main;
  logic          load_skid;

  logic [CNT_W-1:0] stall_q;

  assign main_valid = state_q[1];
  assign skid_valid = state_q[0];

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  assign in_ready  = !reset && !skid_valid && !flush;
  assign out_valid = main_valid;
  assign accept    = in_valid && in_ready;
  assign fire      = main_valid && out_ready;

  assign in_payload = {in_a, in_b, in_alu_op, in_rd, wb_enable(in_rd, in_reg_write)};

  // ---------------------------------------------------------------------------
  // Payload load control. Flush suppresses loads: entries are discarded anyway,
  // and keeping main untouched avoids needless toggling on squash.
  // ---------------------------------------------------------------------------
  always_comb begin
    load_main = 1'b0;
    load_skid = 1'b0;
    main_d    = in_payload;
    if (!flush) begin
      case (state_q)
        StEmpty: begin
          load_main = accept;
        end
        StFull: begin
          if (accept && fire) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
          end
        end
        StSkid: begin
          // Older entry leaves; promote the skid entry to keep FIFO order.
          if (fire) begin
            load_main = 1'b1;
            main_d    = skid_q;
          end
        end
        default: begin
          load_main = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Occupancy FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StEmpty;
    end else if (flush) begin
      state_q <= StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) state_q <= StFull;
        end
        StFull: begin
          if (accept && !fire) begin
            state_q <= StSkid;
          end else if (!accept && fire) begin
            state_q <= StEmpty;
          end
        end
        StSkid: begin
          if (fire) state_q <= StFull;
        end
        default: begin
          state_q <= StEmpty;
        end
      endcase
    end
  end

  // A skid entry without a main entry would break FIFO ordering.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(skid_valid && !main_valid));
    end
  end

  // ---------------------------------------------------------------------------
  // Payload storage
  // ---------------------------------------------------------------------------
  ex_payload_reg #(
    .W (PW)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (load_main),
    .d     (main_d),
    .q     (main_q)
  );

  ex_payload_reg #(
    .W (PW)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (load_skid),
    .d     (in_payload),
    .q     (skid_q)
  );

  assign {out_a, out_b, out_alu_op, out_rd, out_reg_write} = main_q;

  // ---------------------------------------------------------------------------
  // Downstream stall counter: saturates, cleared only by reset.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && !flush && (stall_q != '1)) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed bench for id_ex_skid_reg. Inputs are driven 1 time unit after each
// rising edge and outputs are checked in the same window, well before the next
// edge. The counter is built 4 bits wide so saturation is reachable quickly.
module tb_id_ex_skid_reg;
  import alu_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 3;
  localparam int unsigned CW = 4;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [OW-1:0] in_alu_op;
  logic [4:0]    in_rd;
  logic          in_reg_write;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [OW-1:0] out_alu_op;
  logic [4:0]    out_rd;
  logic          out_reg_write;
  logic [CW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  id_ex_skid_reg #(
    .DATA_W (DW),
    .OP_W   (OW),
    .CNT_W  (CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_alu_op     (in_alu_op),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_alu_op    (out_alu_op),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write),
    .stall_cycles  (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_alu_op    = '0;
    in_rd        = '0;
    in_reg_write = 1'b0;
    out_ready    = 1'b0;

    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_stall", 32'(stall_cycles), 32'd0);
    chk("rst_out_a", out_a, 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Streaming: 1,2,3,4 back to back with EX always ready
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_a         = 32'd1;
    in_b         = 32'd100;
    in_alu_op    = ALU_ADD;
    in_rd        = 5'd5;
    in_reg_write = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("str_out_valid", 32'(out_valid), 32'd1);
      chk("str_out_a", out_a, 32'(i));
      chk("str_in_ready", 32'(in_ready), 32'd1);
      if (i < 4) in_a = 32'(i + 1);
      else in_valid = 1'b0;
    end
    chk("str_out_rd", 32'(out_rd), 32'd5);
    chk("str_out_we", 32'(out_reg_write), 32'd1);
    step();
    chk("str_drain_valid", 32'(out_valid), 32'd0);
    chk("str_stall", 32'(stall_cycles), 32'd0);

    // Back-pressure: 10 in main, 11 in skid, 12 held upstream
    in_valid = 1'b1;
    in_a     = 32'd10;
    step();
    out_ready = 1'b0;
    in_a      = 32'd11;
    chk("bp_main10", out_a, 32'd10);
    chk("bp_ready_full", 32'(in_ready), 32'd1);
    step();
    in_a = 32'd12;
    chk("bp_ready_skid", 32'(in_ready), 32'd0);
    chk("bp_hold10", out_a, 32'd10);
    chk("bp_stall1", 32'(stall_cycles), 32'd1);
    step();
    chk("bp_stable10", out_a, 32'd10);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_stall2", 32'(stall_cycles), 32'd2);
    out_ready = 1'b1;
    step();
    chk("bp_out11", out_a, 32'd11);
    chk("bp_ready_after", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_out12", out_a, 32'd12);
    chk("bp_valid12", 32'(out_valid), 32'd1);
    step();
    chk("bp_drained", 32'(out_valid), 32'd0);
    chk("bp_stall_final", 32'(stall_cycles), 32'd2);

    // Flush while in SKID: 20 in main, 21 in skid
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd20;
    step();
    in_a = 32'd21;
    step();
    chk("fl_main20", out_a, 32'd20);
    chk("fl_skid_ready", 32'(in_ready), 32'd0);
    chk("fl_stall3", 32'(stall_cycles), 32'd3);
    flush = 1'b1;
    in_a  = 32'd22;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_in_ready", 32'(in_ready), 32'd1);
    chk("fl_stall_nochg", 32'(stall_cycles), 32'd3);
    // Offer during a flush from EMPTY: must not be taken
    in_valid = 1'b1;
    in_a     = 32'd23;
    flush    = 1'b1;
    #1;
    chk("fl_ready_low", 32'(in_ready), 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_not_accepted", 32'(out_valid), 32'd0);

    // x0 suppression with SLL
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    in_a         = 32'hDEAD_BEEF;
    in_b         = 32'h0000_1234;
    in_alu_op    = ALU_SLL;
    in_rd        = 5'd0;
    in_reg_write = 1'b1;
    step();
    in_alu_op = 3'd7;
    in_rd     = 5'd3;
    in_a      = 32'd7;
    chk("x0_valid", 32'(out_valid), 32'd1);
    chk("x0_we", 32'(out_reg_write), 32'd0);
    chk("x0_op", 32'(out_alu_op), 32'd5);
    chk("x0_a", out_a, 32'hDEAD_BEEF);
    chk("x0_b", out_b, 32'h0000_1234);
    chk("x0_rd", 32'(out_rd), 32'd0);
    step();
    in_valid = 1'b0;
    chk("op7_pass", 32'(out_alu_op), 32'd7);
    chk("op7_we", 32'(out_reg_write), 32'd1);
    chk("op7_a", out_a, 32'd7);
    step();
    chk("op7_drained", 32'(out_valid), 32'd0);

    // Counter saturation: start from 3, stall for 20 edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 32'd40;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("sat_14", 32'(stall_cycles), 32'd14);
    for (int i = 0; i < 9; i++) step();
    chk("sat_15", 32'(stall_cycles), 32'd15);
    chk("sat_valid", 32'(out_valid), 32'd1);
    chk("sat_hold40", out_a, 32'd40);

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_stall", 32'(stall_cycles), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd0);
    chk("arst_out_a", out_a, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("arst_after_ready", 32'(in_ready), 32'd1);
    chk("arst_after_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
